mem_sample_engine: RTL

Parametrised sample packer/unpacker between the AC97 sample stream and the ZBT SRAM banks; successor to the fixed 3×12-bit, 2-bank memory processor. Packs `SAMPLES_PER_WORD` samples of `SAMPLE_W` bits per memory word and supports `NUM_BANKS` banks. Adds read prefetch, end-of-song partial-word flush, and an optional overdub mode. Sits between the AC97 interface, the address calculator (which owns addresses and steps on `word_advance`) and the ZBT controllers.

---
 rtl/mem_sample_engine_pkg.sv | 29 ++
 rtl/sat_mixer.sv | 24 ++
 rtl/mem_sample_engine.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_sample_engine_pkg.sv
// Shared encodings and defaults for the sample packer/unpacker between AC97 and ZBT.
// Combinational helpers only; no latency and no flow control.
package mem_sample_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_PLAY = 2'b00,
        MODE_REC  = 2'b01,
        MODE_DUB  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam int DEF_SAMPLE_W         = 12;
    localparam int DEF_SAMPLES_PER_WORD = 3;
    localparam int DEF_NUM_BANKS        = 2;
    localparam int DEF_RD_LAT           = 2;

    // Slot 0 sits in the MSBs of a word, the last slot in the LSBs.
    function automatic int slot_lsb(input int slot, input int spw, input int w);
        return (spw - 1 - slot) * w;
    endfunction

endpackage

// File: rtl/sat_mixer.sv
// Signed add of two samples clamped to the W-bit signed range.
// Purely combinational; no flow control.
module sat_mixer #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);

    logic signed [W:0] sum_full;

    assign sum_full = a_i + b_i;

    // Overflow shows as disagreement between the two top bits of the wide sum.
    always_comb begin
        if (sum_full[W] != sum_full[W-1]) begin
            sum_o = sum_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sum_o = sum_full[W-1:0];
        end
    end

endmodule

// File: rtl/mem_sample_engine.sv
// Packs/unpacks AC97 samples into ZBT words with prefetch, flush and optional overdub (MEM_SAMPLE_ENGINE_OVERDUB_EN).
// audio_out one cycle after ready; we/mem_wr_data/word_advance one cycle after the completing ready or song_done.
// No backpressure: ready strobes must be spaced more than RD_LAT+2 cycles; strobes in non-RUN states are dropped.
module mem_sample_engine
    import mem_sample_engine_pkg::*;
#(
    parameter int SAMPLE_W         = DEF_SAMPLE_W,
    parameter int SAMPLES_PER_WORD = DEF_SAMPLES_PER_WORD,
    parameter int NUM_BANKS        = DEF_NUM_BANKS,
    parameter int RD_LAT           = DEF_RD_LAT
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                ready,
    input  logic [SAMPLE_W-1:0]                                 audio_in,
    input  logic                                                start_song,
    input  logic                                                pause_song,
    input  logic                                                song_done,
    input  logic [1:0]                                          mode,
    input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] bank_sel,
    input  logic [NUM_BANKS*SAMPLE_W*SAMPLES_PER_WORD-1:0]      mem_rd_data,
    output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0]                mem_wr_data,
    output logic [NUM_BANKS-1:0]                                we,
    output logic                                                word_advance,
    output logic [SAMPLE_W-1:0]                                 audio_out,
    output logic [1:0]                                          state
);

    localparam int WORD_W = SAMPLE_W * SAMPLES_PER_WORD;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int SLOT_W = $clog2(SAMPLES_PER_WORD);
    localparam logic [RD_LAT:0] ARM_SEED = 1;

    state_e               state_q;
    mode_e                mode_q, mode_dec;
    logic [BANK_W-1:0]    bank_q;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [WORD_W-1:0]    pack_q, pack_d;
    logic [WORD_W-1:0]    play_q, pref_q, wr_data_q;
    logic [NUM_BANKS-1:0] we_q, bank_onehot;
    logic                 adv_q, flush_pend_q;
    logic [SAMPLE_W-1:0]  audio_q;
    logic [RD_LAT:0]      arm_q;

    logic [WORD_W-1:0]    cur_word;
    logic [SAMPLE_W-1:0]  play_smp, out_smp;
    logic                 wrap, writing;
    int                   lsb;

    always_comb begin
        mode_dec = MODE_PLAY;
        case (mode)
            2'b01:   mode_dec = MODE_REC;
`ifdef MEM_SAMPLE_ENGINE_OVERDUB_EN
            2'b10:   mode_dec = MODE_DUB;
`endif
            default: mode_dec = MODE_PLAY;
        endcase
    end

    // The prefetched word becomes the play word as its first slot is consumed,
    // which is after the capture triggered by the previous wrap has landed.
    assign cur_word    = (slot_q == '0) ? pref_q : play_q;
    assign lsb         = slot_lsb(int'(slot_q), SAMPLES_PER_WORD, SAMPLE_W);
    assign play_smp    = cur_word[lsb +: SAMPLE_W];
    assign wrap        = (slot_q == SLOT_W'(SAMPLES_PER_WORD - 1));
    assign slot_d      = wrap ? '0 : slot_q + SLOT_W'(1);
    assign writing     = (mode_q == MODE_REC) || (mode_q == MODE_DUB);
    assign bank_onehot = NUM_BANKS'(1) << bank_q;

`ifdef MEM_SAMPLE_ENGINE_OVERDUB_EN
    logic [SAMPLE_W-1:0] mix_smp;

    sat_mixer #(.W(SAMPLE_W)) u_sat_mixer (
        .a_i   (play_smp),
        .b_i   (audio_in),
        .sum_o (mix_smp)
    );
`endif

    always_comb begin
        out_smp = play_smp;
        case (mode_q)
            MODE_REC: out_smp = audio_in;
`ifdef MEM_SAMPLE_ENGINE_OVERDUB_EN
            MODE_DUB: out_smp = mix_smp;
`endif
            default:  out_smp = play_smp;
        endcase
    end

    always_comb begin
        pack_d = pack_q;
        pack_d[lsb +: SAMPLE_W] = out_smp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_PLAY;
            bank_q       <= '0;
            slot_q       <= '0;
            pack_q       <= '0;
            play_q       <= '0;
            pref_q       <= '0;
            wr_data_q    <= '0;
            we_q         <= '0;
            adv_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            audio_q      <= '0;
            arm_q        <= '0;
        end else begin
            we_q  <= '0;
            adv_q <= 1'b0;
            arm_q <= arm_q << 1;
            if (arm_q[RD_LAT]) begin
                pref_q <= mem_rd_data[int'(bank_q)*WORD_W +: WORD_W];
            end

            if (start_song) begin
                mode_q       <= mode_dec;
                bank_q       <= bank_sel;
                slot_q       <= '0;
                pack_q       <= '0;
                play_q       <= '0;
                pref_q       <= '0;
                arm_q        <= ARM_SEED;
                flush_pend_q <= 1'b0;
                state_q      <= ST_RUN;
            end else if (flush_pend_q) begin
                flush_pend_q <= 1'b0;
                state_q      <= ST_DONE;
            end else if (song_done && (state_q == ST_RUN || state_q == ST_PAUSED)) begin
                // A partial word is written once with its unused slots left at zero.
                if (writing && slot_q != '0) begin
                    wr_data_q    <= pack_q;
                    we_q         <= bank_onehot;
                    adv_q        <= 1'b1;
                    slot_q       <= '0;
                    pack_q       <= '0;
                    flush_pend_q <= 1'b1;
                end else begin
                    state_q <= ST_DONE;
                end
            end else if (state_q == ST_RUN) begin
                if (pause_song) begin
                    state_q <= ST_PAUSED;
                end else if (ready) begin
                    slot_q  <= slot_d;
                    audio_q <= out_smp;
                    if (slot_q == '0) begin
                        play_q <= pref_q;
                    end
                    if (wrap) begin
                        adv_q  <= 1'b1;
                        pack_q <= '0;
                        arm_q  <= (arm_q << 1) | ARM_SEED;
                        if (writing) begin
                            wr_data_q <= pack_d;
                            we_q      <= bank_onehot;
                        end
                    end else begin
                        pack_q <= pack_d;
                    end
                end
            end else if (state_q == ST_PAUSED && !pause_song) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign mem_wr_data  = wr_data_q;
    assign we           = we_q;
    assign word_advance = adv_q;
    assign audio_out    = audio_q;
    assign state        = state_q;

endmodule
